ex_muldiv_seq: RTL

Multi-cycle multiply/divide sequencer attached to the EX stage. It serves MULT, MULTU, DIV and DIVU and produces the HI/LO result pair.
- EX asserts start_i while such an instruction sits in EX.
- The block drives stall_o back into EX's stall_request until the result is ready, then pulses done_o with hi_o/lo_o for the HI/LO write path.
- One shared radix-2 iterative engine serves all four ops.

---
 rtl/ex_muldiv_seq_pkg.sv | 32 +++
 rtl/ex_muldiv_seq_if.sv | 29 ++
 rtl/ex_muldiv_seq_muldiv_step.sv | 40 ++++
 rtl/ex_muldiv_seq.sv | 131 +++++++++++++
 4 files changed

// File: rtl/ex_muldiv_seq_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer.
//   md_op_e    : operation codes as presented on op_i
//   md_state_e : sequencer FSM states
//   RESET_ENABLE : lets the synchronous reset be compiled out of the datapath
package ex_muldiv_seq_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

  localparam bit RESET_ENABLE = 1'b1;

  // op[1] selects divide, op[0] selects unsigned
  function automatic logic op_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/ex_muldiv_seq_if.sv
// EX <-> mul/div sequencer handshake bundle.
//   master : EX side (drives start/cancel/op/operands, receives stall/result)
//   slave  : sequencer side
interface ex_muldiv_seq_if
  import ex_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             cancel_i;
  md_op_e           op_i;
  logic [WIDTH-1:0] operand_a_i;
  logic [WIDTH-1:0] operand_b_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, cancel_i, op_i, operand_a_i, operand_b_i,
    input  stall_o, busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, cancel_i, op_i, operand_a_i, operand_b_i,
    output stall_o, busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_muldiv_seq_muldiv_step.sv
// One radix-2 iteration of the shared mul/div engine (combinational).
//   is_div          : 0 = add-shift multiply, 1 = restoring divide
//   acc_hi/acc_lo   : current accumulator (mul: partial product / multiplier,
//                     div: remainder / dividend-becoming-quotient)
//   opnd            : multiplicand (mul) or divisor (div), magnitude only
//   acc_hi_nxt/_lo_nxt : accumulator after this iteration
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_hi_nxt,
  output logic [WIDTH-1:0] acc_lo_nxt
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           ge;

  // multiply: carry out of the add becomes the new MSB after the shift
  assign sum = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opnd}) : {1'b0, acc_hi};

  // divide: rem shifted left with next dividend bit; WIDTH+1 bits so the
  // shifted-out MSB still takes part in the compare
  assign rem_sh = {acc_hi, acc_lo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, opnd};
  assign ge     = rem_sh >= {1'b0, opnd};

  always_comb begin
    acc_hi_nxt = sum[WIDTH:1];
    acc_lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      // remainder stays below the divisor, so the low WIDTH bits suffice
      acc_hi_nxt = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      acc_lo_nxt = {acc_lo[WIDTH-2:0], ge};
    end
  end
endmodule

// File: rtl/ex_muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage.
//   clk, reset : clock, synchronous active-high reset
//   md (slave) : start/cancel/op/operands in; stall/busy/done/hi/lo out
// Operands are reduced to magnitudes on entry, iterated WIDTH times by
// muldiv_step, then sign-corrected in FIX before the HI/LO registers load.
module ex_muldiv_seq
  import ex_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  ex_muldiv_seq_if.slave  md
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  md_op_e           op;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] hi_q, lo_q;

  // entry decode
  logic             accept, in_div, in_sgn, a_neg, b_neg, div_zero;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign accept   = (state == MD_IDLE) & md.start_i & ~md.cancel_i;
  assign in_div   = op_is_div(md.op_i);
  assign in_sgn   = op_is_signed(md.op_i);
  assign a_neg    = in_sgn & md.operand_a_i[WIDTH-1];
  assign b_neg    = in_sgn & md.operand_b_i[WIDTH-1];
  assign abs_a    = a_neg ? -md.operand_a_i : md.operand_a_i;
  assign abs_b    = b_neg ? -md.operand_b_i : md.operand_b_i;
  assign div_zero = in_div & (md.operand_b_i == '0);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div     (op_is_div(op)),
    .acc_hi     (acc_hi),
    .acc_lo     (acc_lo),
    .opnd       (opnd),
    .acc_hi_nxt (step_hi),
    .acc_lo_nxt (step_lo)
  );

  // sign correction
  logic [2*WIDTH-1:0] prod, prod_neg;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign prod     = {acc_hi, acc_lo};
  assign prod_neg = -prod;

  always_comb begin
    fix_hi = acc_hi;
    fix_lo = acc_lo;
    if (op_is_signed(op)) begin
      if (op_is_div(op)) begin
        if (sign_a ^ sign_b) fix_lo = -acc_lo;
        if (sign_a)          fix_hi = -acc_hi;
      end else if (sign_a ^ sign_b) begin
        {fix_hi, fix_lo} = prod_neg;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (accept) state_nxt = div_zero ? MD_DONE : MD_RUN;
      MD_RUN: begin
        if (md.cancel_i)        state_nxt = MD_IDLE;
        else if (cnt == LAST)   state_nxt = MD_FIX;
      end
      MD_FIX:  state_nxt = md.cancel_i ? MD_IDLE : MD_DONE;
      // start_i still belongs to the finished instruction here
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET_ENABLE && reset) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      op     <= MD_MULT;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        MD_IDLE: if (accept) begin
          op     <= md.op_i;
          sign_a <= a_neg;
          sign_b <= b_neg;
          cnt    <= '0;
          acc_hi <= '0;
          acc_lo <= in_div ? abs_a : abs_b;
          opnd   <= in_div ? abs_b : abs_a;
          if (div_zero) begin
            hi_q <= md.operand_a_i;
            lo_q <= '1;
          end
        end
        MD_RUN: if (!md.cancel_i) begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
        end
        MD_FIX: if (!md.cancel_i) begin
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign md.stall_o = ~md.cancel_i & (((state == MD_IDLE) & md.start_i) |
                                      (state == MD_RUN) | (state == MD_FIX));
  assign md.busy_o  = (state != MD_IDLE);
  assign md.done_o  = (state == MD_DONE);
  assign md.hi_o    = hi_q;
  assign md.lo_o    = lo_q;
endmodule
